// File: rtl/ip_hdr_gen.sv
// ip_hdr_gen: builds a 20-byte IPv4 header (no options) on request and
// streams it out in network byte order, DATA_BYTES bytes per beat.
//
// The header checksum is computed serially: one 16-bit header word is added
// per cycle into a 20-bit accumulator (SUM, 10 cycles), then the carries are
// folded and the result inverted (FOLD, 1 cycle). The finished header is
// loaded into a 160-bit shift register and drained under valid/ready (SEND).
// The Identification field increments after each completed header.
//
// Parameters
//   DATA_BYTES  bytes per output beat (1, 2 or 4)
//   TTL         Time To Live byte
//   PROTO       protocol byte
//   ID_INIT     Identification value after reset
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start             one-cycle request; sa, da, payload_len sampled with it
//   sa, da            source / destination address
//   payload_len       payload bytes; total length = payload_len + 20
//   out_data          header beat, first byte in the most significant lane
//   out_valid         out_data holds a valid beat
//   out_ready         downstream accepts the beat
//   out_last          final beat of the header
//   busy              any state other than IDLE
//   len_err           one-cycle pulse when a start is rejected (length overflow)
module ip_hdr_gen #(
  parameter int          DATA_BYTES = 1,
  parameter logic [7:0]  TTL        = 8'd64,
  parameter logic [7:0]  PROTO      = 8'd6,
  parameter logic [15:0] ID_INIT    = 16'h0001
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [31:0]               sa,
  input  logic [31:0]               da,
  input  logic [15:0]               payload_len,
  output logic [8*DATA_BYTES-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      len_err
);

  localparam int LANE_W = 8 * DATA_BYTES;
  localparam int BEATS  = 20 / DATA_BYTES;

  typedef enum logic [1:0] {IDLE, SUM, FOLD, SEND} state_t;

  state_t       state, state_nxt;
  logic [3:0]   word_idx;
  logic [4:0]   beat_idx;
  logic [15:0]  id;
  logic         len_err_r;

  logic [31:0]  sa_r, da_r;
  logic [15:0]  tot_len;
  logic [19:0]  acc;
  logic [159:0] shreg;
  logic [15:0]  sum_word;

  logic         len_ok;
  logic         last_beat;

  // Two end-around-carry folds are always enough for a sum of ten 16-bit
  // words: after the first fold the value is at most 0x1000E, so the second
  // fold cannot carry again.
  function automatic logic [15:0] fold_csum(input logic [19:0] a);
    logic [19:0] f1;
    logic [15:0] f2;
    f1 = {4'd0, a[15:0]} + {16'd0, a[19:16]};
    f2 = f1[15:0] + {12'd0, f1[19:16]};
    return ~f2;
  endfunction

  // Largest payload whose total length still fits in 16 bits.
  assign len_ok    = (payload_len <= 16'd65515);
  assign last_beat = (beat_idx == 5'(BEATS - 1));
  assign len_err   = len_err_r;

  // Header word fed to the checksum adder; the checksum field counts as zero.
  always_comb begin
    sum_word = 16'h0000;
    case (word_idx)
      4'd0:    sum_word = 16'h4500;
      4'd1:    sum_word = tot_len;
      4'd2:    sum_word = id;
      4'd3:    sum_word = 16'h4000;
      4'd4:    sum_word = {TTL, PROTO};
      4'd6:    sum_word = sa_r[31:16];
      4'd7:    sum_word = sa_r[15:0];
      4'd8:    sum_word = da_r[31:16];
      4'd9:    sum_word = da_r[15:0];
      default: sum_word = 16'h0000;
    endcase
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && len_ok) state_nxt = SUM;
      end
      SUM: begin
        if (word_idx == 4'd9) state_nxt = FOLD;
      end
      FOLD: begin
        state_nxt = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = last_beat;
        out_data  = shreg[159 -: LANE_W];
        if (out_ready && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      id        <= ID_INIT;
      word_idx  <= 4'd0;
      beat_idx  <= 5'd0;
      len_err_r <= 1'b0;
    end else begin
      state     <= state_nxt;
      len_err_r <= (state == IDLE) && start && !len_ok;
      if (state == SUM) word_idx <= word_idx + 4'd1;
      else              word_idx <= 4'd0;
      if (state == SEND && out_ready) begin
        if (last_beat) begin
          beat_idx <= 5'd0;
          id       <= id + 16'd1;
        end else begin
          beat_idx <= beat_idx + 5'd1;
        end
      end
    end
  end

  // Datapath registers: capture on accepted start, accumulate, fold, drain.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start && len_ok) begin
          sa_r    <= sa;
          da_r    <= da;
          tot_len <= payload_len + 16'd20;
          acc     <= '0;
        end
      end
      SUM:  acc   <= acc + {4'd0, sum_word};
      FOLD: shreg <= {16'h4500, tot_len, id, 16'h4000, TTL, PROTO,
                      fold_csum(acc), sa_r, da_r};
      SEND: if (out_ready) shreg <= shreg << LANE_W;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ip_hdr_gen.sv
// Bench for ip_hdr_gen. Three instances share start/sa/da/payload_len/rst:
//   0: DATA_BYTES=1, PROTO=17, ID_INIT=0
//   1: DATA_BYTES=4, PROTO=17, ID_INIT=0
//   2: DATA_BYTES=2, PROTO=6,  ID_INIT=FFFF
// 'sel' picks the instance under observation; the others always see ready=1.
module tb_ip_hdr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [31:0] sa, da;
  logic [15:0] plen;
  int          sel;
  logic        rdy_sel;

  logic        rdy0, rdy1, rdy2;
  logic [7:0]  d0;
  logic [31:0] d1;
  logic [15:0] d2;
  logic        v0, v1, v2, l0, l1, l2, b0, b1, b2, e0, e1, e2;

  assign rdy0 = (sel == 0) ? rdy_sel : 1'b1;
  assign rdy1 = (sel == 1) ? rdy_sel : 1'b1;
  assign rdy2 = (sel == 2) ? rdy_sel : 1'b1;

  ip_hdr_gen #(.DATA_BYTES(1), .PROTO(8'd17), .ID_INIT(16'h0000)) u0 (
    .clk(clk), .rst(rst), .start(start), .sa(sa), .da(da), .payload_len(plen),
    .out_data(d0), .out_valid(v0), .out_ready(rdy0), .out_last(l0),
    .busy(b0), .len_err(e0));

  ip_hdr_gen #(.DATA_BYTES(4), .PROTO(8'd17), .ID_INIT(16'h0000)) u1 (
    .clk(clk), .rst(rst), .start(start), .sa(sa), .da(da), .payload_len(plen),
    .out_data(d1), .out_valid(v1), .out_ready(rdy1), .out_last(l1),
    .busy(b1), .len_err(e1));

  ip_hdr_gen #(.DATA_BYTES(2), .PROTO(8'd6), .ID_INIT(16'hFFFF)) u2 (
    .clk(clk), .rst(rst), .start(start), .sa(sa), .da(da), .payload_len(plen),
    .out_data(d2), .out_valid(v2), .out_ready(rdy2), .out_last(l2),
    .busy(b2), .len_err(e2));

  logic [31:0] md;
  logic        mv, ml, mb, me;
  always_comb begin
    md = 32'd0; mv = 1'b0; ml = 1'b0; mb = 1'b0; me = 1'b0;
    case (sel)
      0:       begin md = {24'd0, d0}; mv = v0; ml = l0; mb = b0; me = e0; end
      1:       begin md = d1;          mv = v1; ml = l1; mb = b1; me = e1; end
      default: begin md = {16'd0, d2}; mv = v2; ml = l2; mb = b2; me = e2; end
    endcase
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] mid [3];

  function automatic int db_of(input int s);
    return (s == 0) ? 1 : (s == 1) ? 4 : 2;
  endfunction

  function automatic logic [7:0] proto_of(input int s);
    return (s == 2) ? 8'd6 : 8'd17;
  endfunction

  function automatic logic [15:0] init_of(input int s);
    return (s == 2) ? 16'hFFFF : 16'h0000;
  endfunction

  // Reference header: ten words, ones-complement sum, inverted into word 5.
  function automatic logic [159:0] model_hdr(input logic [7:0] proto, input logic [15:0] id,
                                             input logic [31:0] s, input logic [31:0] d,
                                             input logic [15:0] p);
    logic [15:0] w [10];
    int sum;
    w[0] = 16'h4500;  w[1] = p + 16'd20;  w[2] = id;          w[3] = 16'h4000;
    w[4] = {8'd64, proto};                w[5] = 16'h0000;
    w[6] = s[31:16];  w[7] = s[15:0];     w[8] = d[31:16];    w[9] = d[15:0];
    sum = 0;
    for (int i = 0; i < 10; i++) sum += int'(w[i]);
    while (sum > 65535) sum = (sum & 65535) + (sum >> 16);
    w[5] = ~sum[15:0];
    return {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7], w[8], w[9]};
  endfunction

  function automatic logic [31:0] beat_of(input logic [159:0] h, input int db, input int b);
    logic [159:0] t;
    t = h << (b * 8 * db);
    return t[159:128] >> (32 - 8 * db);
  endfunction

  task automatic init_ids();
    for (int i = 0; i < 3; i++) mid[i] = init_of(i);
  endtask

  task automatic bump_ids();
    for (int i = 0; i < 3; i++) mid[i] = mid[i] + 16'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; rdy_sel = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    init_ids();
  endtask

  // Caller is at #1 after a rising edge; ends at #1 after the edge that samples start.
  task automatic start_pkt(input logic [31:0] s, input logic [31:0] d, input logic [15:0] p);
    sa = s; da = d; plen = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (mb !== 1'b1) begin
      n_fail++; $display("FAIL start_busy: busy=%b required 1", mb);
    end
  endtask

  // k0 = cycles already elapsed since start was sampled.
  task automatic collect_pkt(input logic [159:0] exp, input bit stall, input int k0);
    int k, nb, beat, cyc, db;
    bit stalled;
    logic [31:0] hold_d, want;
    logic hold_l;
    db = db_of(sel);
    nb = 20 / db;
    k = k0;
    while (!mv && k < 40) begin @(posedge clk); #1; k++; end
    n_checks++;
    if (k != 11) begin
      n_fail++; $display("FAIL valid_latency: edges=%0d required 11", k);
    end
    beat = 0; cyc = 0; stalled = 0; hold_d = '0; hold_l = 1'b0;
    while (beat < nb && cyc < 2000) begin
      if (stalled) begin
        n_checks++;
        if (mv !== 1'b1 || md !== hold_d || ml !== hold_l) begin
          n_fail++;
          $display("FAIL stall_hold: v=%b data=%h last=%b required v=1 data=%h last=%b",
                   mv, md, ml, hold_d, hold_l);
        end
      end
      rdy_sel = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rdy_sel) begin
        want = beat_of(exp, db, beat);
        n_checks++;
        if (mv !== 1'b1 || md !== want || ml !== (beat == nb - 1)) begin
          n_fail++;
          $display("FAIL beat%0d: v=%b data=%h last=%b required v=1 data=%h last=%b",
                   beat, mv, md, ml, want, (beat == nb - 1));
        end
        beat++;
        stalled = 0;
      end else begin
        hold_d = md; hold_l = ml; stalled = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rdy_sel = 1'b1;
    n_checks++;
    if (cyc >= 2000) begin
      n_fail++; $display("FAIL send_timeout: beats=%0d required %0d", beat, nb);
    end
    n_checks++;
    if (mv !== 1'b0 || ml !== 1'b0 || md !== 32'd0 || mb !== 1'b0) begin
      n_fail++;
      $display("FAIL post_last: v=%b last=%b data=%h busy=%b required all 0", mv, ml, md, mb);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((b0 | b1 | b2) && k < 100) begin @(posedge clk); #1; k++; end
    n_checks++;
    if (k >= 100) begin
      n_fail++; $display("FAIL idle_timeout: busy=%b%b%b required 000", b0, b1, b2);
    end
  endtask

  task automatic run_pkt(input logic [31:0] s, input logic [31:0] d, input logic [15:0] p,
                         input bit stall);
    logic [159:0] exp;
    exp = model_hdr(proto_of(sel), mid[sel], s, d, p);
    start_pkt(s, d, p);
    collect_pkt(exp, stall, 0);
    wait_idle();
    bump_ids();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sa = '0; da = '0; plen = '0; rdy_sel = 1'b1; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      n_checks++;
      if ({mv, ml, mb, me, md} !== 36'd0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: v=%b last=%b busy=%b err=%b data=%h required all 0",
                 s, mv, ml, mb, me, md);
      end
    end
    sel = 0;
    // rst wins over a simultaneous start
    rst = 1'b1; start = 1'b1; plen = 16'd10;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    n_checks++;
    if (mb !== 1'b0) begin n_fail++; $display("FAIL rst_priority: busy=%b required 0", mb); end
    // reset in the middle of SUM
    start_pkt(32'h01020304, 32'h05060708, 16'd100);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (mb !== 1'b0 || mv !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_sum: busy=%b v=%b required 0 0", mb, mv);
    end
    @(posedge clk); #1;
    n_checks++;
    if (b0 | b1 | b2) begin
      n_fail++; $display("FAIL rst_mid_sum_idle: busy=%b%b%b required 000", b0, b1, b2);
    end
    init_ids();
  endtask

  localparam logic [159:0] REF_HDR = 160'h45000073_00004000_4011B861_C0A80001_C0A800C7;

  task automatic test_vector_db1();
    do_reset();
    sel = 0;
    start_pkt(32'hC0A80001, 32'hC0A800C7, 16'h005F);
    collect_pkt(REF_HDR, 1'b0, 0);
    wait_idle();
    bump_ids();
  endtask

  task automatic test_vector_db4();
    do_reset();
    sel = 1;
    start_pkt(32'hC0A80001, 32'hC0A800C7, 16'h005F);
    collect_pkt(REF_HDR, 1'b0, 0);
    wait_idle();
    bump_ids();
  endtask

  task automatic test_id_wrap();
    do_reset();
    sel = 2;
    run_pkt($urandom, $urandom, 16'($urandom_range(0, 1500)), 1'b0);
    run_pkt($urandom, $urandom, 16'($urandom_range(0, 1500)), 1'b0);
  endtask

  task automatic test_random_stall();
    for (int i = 0; i < 6; i++) begin
      sel = i % 3;
      run_pkt($urandom, $urandom, 16'($urandom_range(0, 65515)), 1'b1);
    end
  endtask

  task automatic test_len_err();
    logic [159:0] exp;
    logic [31:0] s, d;
    sel = 0;
    sa = $urandom; da = $urandom; plen = 16'd65516; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (me !== 1'b1 || mb !== 1'b0) begin
      n_fail++; $display("FAIL len_err_pulse: err=%b busy=%b required 1 0", me, mb);
    end
    @(posedge clk); #1;
    n_checks++;
    if (me !== 1'b0 || mb !== 1'b0) begin
      n_fail++; $display("FAIL len_err_clear: err=%b busy=%b required 0 0", me, mb);
    end
    // maximum legal length; Identification must be untouched by the rejection
    run_pkt($urandom, $urandom, 16'd65515, 1'b0);
    // a start while busy is ignored and raises no len_err
    s = $urandom; d = $urandom;
    exp = model_hdr(proto_of(sel), mid[sel], s, d, 16'd40);
    start_pkt(s, d, 16'd40);
    sa = $urandom; da = $urandom; plen = 16'd65516; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (me !== 1'b0) begin n_fail++; $display("FAIL busy_start_err: err=%b required 0", me); end
    collect_pkt(exp, 1'b0, 1);
    wait_idle();
    bump_ids();
  endtask

  task automatic test_back_to_back();
    logic [159:0] exp1, exp2;
    logic [31:0] s1, d1v, s2, d2v;
    sel = 0;
    s1 = $urandom; d1v = $urandom; s2 = $urandom; d2v = $urandom;
    exp1 = model_hdr(proto_of(sel), mid[sel], s1, d1v, 16'd512);
    start_pkt(s1, d1v, 16'd512);
    collect_pkt(exp1, 1'b0, 0);
    bump_ids();
    exp2 = model_hdr(proto_of(sel), mid[sel], s2, d2v, 16'd7);
    start_pkt(s2, d2v, 16'd7);
    collect_pkt(exp2, 1'b0, 0);
    wait_idle();
    bump_ids();
  endtask

  task automatic test_reset_mid_send();
    int k;
    sel = 0;
    start_pkt($urandom, $urandom, 16'd64);
    k = 0;
    while (!mv && k < 40) begin @(posedge clk); #1; k++; end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (mv !== 1'b1) begin n_fail++; $display("FAIL third_beat_valid: v=%b required 1", mv); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (mv !== 1'b0 || ml !== 1'b0 || mb !== 1'b0 || md !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_send: v=%b last=%b busy=%b data=%h required all 0", mv, ml, mb, md);
    end
    init_ids();
    wait_idle();
    run_pkt($urandom, $urandom, 16'($urandom_range(0, 9000)), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    init_ids();
    test_reset();
    test_vector_db1();
    test_vector_db4();
    test_id_wrap();
    test_random_stall();
    test_len_err();
    test_back_to_back();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
